cond_eval_unit: RTL and testbench

//  Registered condition-evaluation stage for the execute path: holds the NZCV flag register,

---
 rtl/cond_eval_unit.sv | 180 ++++++++++++++++++
 tb/tb_cond_eval_unit.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/cond_eval_unit.sv
// Condition-evaluation stage: NZCV flag register, 4-bit condition check per accepted
// instruction (optional flag bypass, legacy 2-bit encoding) and predicated-block sequencing.
module cond_eval_unit #(
    parameter int LEGACY_MODE = 0,
    parameter int BYPASS      = 1,
    parameter int MAX_PRED    = 4,
    parameter int PCNT_W      = 3
) (
    input  logic                i_clock,
    input  logic                i_reset,
    input  logic                i_flag_we,
    input  logic [3:0]          i_flag_in,
    input  logic [3:0]          i_flag_mask,
    input  logic                i_cond_valid,
    input  logic [3:0]          i_cond,
    input  logic                i_stall,
    input  logic                i_flush,
    input  logic                i_pred_start,
    input  logic [PCNT_W-1:0]   i_pred_len,
    input  logic [3:0]          i_pred_cond,
    input  logic [MAX_PRED-1:0] i_pred_mask,
    output logic                o_out_valid,
    output logic                o_out,
    output logic [3:0]          o_flag_out,
    output logic                o_pred_active
);

    function automatic logic f_eval_cond(input logic [3:0] cond, input logic [3:0] flags,
                                         input logic legacy);
        logic n, z, c, v, pass;
        n = flags[3];
        z = flags[2];
        c = flags[1];
        v = flags[0];
        pass = 1'b0;
        if (legacy) begin
            case (cond[1:0])
                2'b00:   pass = 1'b1;
                2'b01:   pass = z;
                2'b10:   pass = ~n;
                2'b11:   pass = n;
                default: pass = 1'b0;
            endcase
        end else begin
            case (cond)
                4'h0:    pass = z;
                4'h1:    pass = ~z;
                4'h2:    pass = c;
                4'h3:    pass = ~c;
                4'h4:    pass = n;
                4'h5:    pass = ~n;
                4'h6:    pass = v;
                4'h7:    pass = ~v;
                4'h8:    pass = c & ~z;
                4'h9:    pass = ~c | z;
                4'hA:    pass = (n == v);
                4'hB:    pass = (n != v);
                4'hC:    pass = ~z & (n == v);
                4'hD:    pass = z | (n != v);
                4'hE:    pass = 1'b1;
                default: pass = 1'b0;
            endcase
        end
        return pass;
    endfunction

    logic [3:0]          r_flags;
    logic                r_out_valid;
    logic                r_out;
    logic                r_pred_active;
    logic [PCNT_W-1:0]   r_count;
    logic [PCNT_W-1:0]   r_index;
    logic [3:0]          r_pred_cond;
    logic [MAX_PRED-1:0] r_pred_mask;

    logic [3:0]          w_flags_next;
    logic [3:0]          w_eval_flags;
    logic                w_len_nonzero;
    logic                w_load;
    logic                w_use_pred;
    logic                w_mask_bit;
    logic [3:0]          w_eff_cond;
    logic                w_pass;
    logic [PCNT_W-1:0]   w_len_clamped;
    logic [PCNT_W-1:0]   w_count_next;
    logic [PCNT_W-1:0]   w_index_next;

    assign w_flags_next  = (i_flag_in & i_flag_mask) | (r_flags & ~i_flag_mask);
    assign w_eval_flags  = ((BYPASS != 0) && i_flag_we) ? w_flags_next : r_flags;
    assign w_len_nonzero = (i_pred_len != {PCNT_W{1'b0}});
    assign w_load        = i_pred_start & ~i_stall & ~i_flush & w_len_nonzero;
    // A pred-setup instruction is judged on its own Cond even if an older block is still live.
    assign w_use_pred    = r_pred_active & ~(i_pred_start & w_len_nonzero);
    assign w_len_clamped = (i_pred_len > PCNT_W'(MAX_PRED)) ? PCNT_W'(MAX_PRED) : i_pred_len;
    assign w_eff_cond    = w_use_pred ? (r_pred_cond ^ {3'b000, w_mask_bit}) : i_cond;
    assign w_pass        = f_eval_cond(w_eff_cond, w_eval_flags, (LEGACY_MODE != 0));

    // Select the inversion bit for the current position within the block.
    always_comb begin
        w_mask_bit = 1'b0;
        for (int i = 0; i < MAX_PRED; i++) begin
            if (r_index == PCNT_W'(i)) begin
                w_mask_bit = r_pred_mask[i];
            end else begin
                w_mask_bit = w_mask_bit;
            end
        end
    end

    // Next-state for the predication counter and block index.
    always_comb begin
        w_count_next = r_count;
        w_index_next = r_index;
        if (i_flush) begin
            w_count_next = {PCNT_W{1'b0}};
            w_index_next = {PCNT_W{1'b0}};
        end else if (i_stall) begin
            w_count_next = r_count;
            w_index_next = r_index;
        end else if (w_load) begin
            w_count_next = w_len_clamped;
            w_index_next = {PCNT_W{1'b0}};
        end else if (i_cond_valid && r_pred_active) begin
            w_count_next = r_count - PCNT_W'(1);
            w_index_next = r_index + PCNT_W'(1);
        end else begin
            w_count_next = r_count;
            w_index_next = r_index;
        end
    end

    // Flag register: masked ALU updates, unaffected by stall and flush.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_flags <= 4'b0000;
        end else if (i_flag_we) begin
            r_flags <= w_flags_next;
        end
    end

    // Predication state and latched block parameters.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_count       <= {PCNT_W{1'b0}};
            r_index       <= {PCNT_W{1'b0}};
            r_pred_active <= 1'b0;
            r_pred_cond   <= 4'b0000;
            r_pred_mask   <= {MAX_PRED{1'b0}};
        end else begin
            r_count       <= w_count_next;
            r_index       <= w_index_next;
            r_pred_active <= (w_count_next != {PCNT_W{1'b0}});
            if (w_load) begin
                r_pred_cond <= i_pred_cond;
                r_pred_mask <= i_pred_mask;
            end
        end
    end

    // Result register: flush kills, stall holds, otherwise capture the accepted evaluation.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_out_valid <= 1'b0;
            r_out       <= 1'b0;
        end else if (i_flush) begin
            r_out_valid <= 1'b0;
        end else if (!i_stall) begin
            r_out_valid <= i_cond_valid;
            if (i_cond_valid) begin
                r_out <= w_pass;
            end
        end
    end

    assign o_out_valid   = r_out_valid;
    assign o_out         = r_out;
    assign o_flag_out    = r_flags;
    assign o_pred_active = r_pred_active;

endmodule

// File: tb/tb_cond_eval_unit.sv
// Directed bench for cond_eval_unit: default, no-bypass and legacy instances share one
// stimulus stream; each check is compared against hand-computed values.
module tb_cond_eval_unit;

    logic       clk;
    logic       rst;
    logic       flag_we;
    logic [3:0] flag_in;
    logic [3:0] flag_mask;
    logic       cond_valid;
    logic [3:0] cond;
    logic       stall;
    logic       flush;
    logic       pred_start;
    logic [2:0] pred_len;
    logic [3:0] pred_cond;
    logic [3:0] pred_mask;

    logic       ov_d, out_d, pa_d;
    logic [3:0] fo_d;
    logic       ov_nb, out_nb, pa_nb;
    logic [3:0] fo_nb;
    logic       ov_lg, out_lg, pa_lg;
    logic [3:0] fo_lg;

    int n_vec = 0;
    int n_err = 0;

    cond_eval_unit dut (
        .i_clock(clk), .i_reset(rst), .i_flag_we(flag_we), .i_flag_in(flag_in),
        .i_flag_mask(flag_mask), .i_cond_valid(cond_valid), .i_cond(cond), .i_stall(stall),
        .i_flush(flush), .i_pred_start(pred_start), .i_pred_len(pred_len),
        .i_pred_cond(pred_cond), .i_pred_mask(pred_mask), .o_out_valid(ov_d), .o_out(out_d),
        .o_flag_out(fo_d), .o_pred_active(pa_d)
    );

    cond_eval_unit #(.BYPASS(0)) dut_nb (
        .i_clock(clk), .i_reset(rst), .i_flag_we(flag_we), .i_flag_in(flag_in),
        .i_flag_mask(flag_mask), .i_cond_valid(cond_valid), .i_cond(cond), .i_stall(stall),
        .i_flush(flush), .i_pred_start(pred_start), .i_pred_len(pred_len),
        .i_pred_cond(pred_cond), .i_pred_mask(pred_mask), .o_out_valid(ov_nb), .o_out(out_nb),
        .o_flag_out(fo_nb), .o_pred_active(pa_nb)
    );

    cond_eval_unit #(.LEGACY_MODE(1)) dut_lg (
        .i_clock(clk), .i_reset(rst), .i_flag_we(flag_we), .i_flag_in(flag_in),
        .i_flag_mask(flag_mask), .i_cond_valid(cond_valid), .i_cond(cond), .i_stall(stall),
        .i_flush(flush), .i_pred_start(pred_start), .i_pred_len(pred_len),
        .i_pred_cond(pred_cond), .i_pred_mask(pred_mask), .o_out_valid(ov_lg), .o_out(out_lg),
        .o_flag_out(fo_lg), .o_pred_active(pa_lg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [3:0] got, input logic [3:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_flags(input logic [3:0] f);
        flag_we = 1'b1; flag_in = f; flag_mask = 4'b1111; cond_valid = 1'b0;
        tick();
        flag_we = 1'b0;
    endtask

    logic [3:0] t3_cond [8] = '{4'hA, 4'hB, 4'hC, 4'hD, 4'h8, 4'h9, 4'hE, 4'hF};
    logic       t3_exp  [8] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    logic       t4_exp  [3] = '{1'b1, 1'b0, 1'b1};

    initial begin
        rst = 1'b1; flag_we = 1'b0; flag_in = 4'h0; flag_mask = 4'h0; cond_valid = 1'b0;
        cond = 4'h0; stall = 1'b0; flush = 1'b0; pred_start = 1'b0; pred_len = 3'd0;
        pred_cond = 4'h0; pred_mask = 4'h0;
        tick(); tick();
        rst = 1'b0;
        chk("rst_ov", {3'b000, ov_d}, 4'h0);
        chk("rst_out", {3'b000, out_d}, 4'h0);
        chk("rst_flags", fo_d, 4'h0);
        chk("rst_pa", {3'b000, pa_d}, 4'h0);

        // Test 1: Z set, EQ then NE
        write_flags(4'b0100);
        chk("t1_flags", fo_d, 4'b0100);
        chk("t1_ov_idle", {3'b000, ov_d}, 4'h0);
        cond_valid = 1'b1; cond = 4'h0;
        tick();
        chk("t1_eq_ov", {3'b000, ov_d}, 4'h1);
        chk("t1_eq", {3'b000, out_d}, 4'h1);
        cond = 4'h1;
        tick();
        chk("t1_ne", {3'b000, out_d}, 4'h0);
        cond_valid = 1'b0;
        tick();
        chk("t1_ov_drop", {3'b000, ov_d}, 4'h0);

        // Test 2: bypass of a same-cycle masked flag write
        write_flags(4'b0000);
        flag_we = 1'b1; flag_in = 4'b1000; flag_mask = 4'b1000; cond_valid = 1'b1; cond = 4'h4;
        tick();
        flag_we = 1'b0; cond_valid = 1'b0;
        chk("t2_bypass", {3'b000, out_d}, 4'h1);
        chk("t2_nobypass", {3'b000, out_nb}, 4'h0);
        chk("t2_flags", fo_d, 4'b1000);

        // Test 3: signed/unsigned compares with N=1 Z=0 C=1 V=0
        write_flags(4'b1010);
        cond_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            cond = t3_cond[i];
            tick();
            chk($sformatf("t3_cond_%h", t3_cond[i]), {3'b000, out_d}, {3'b000, t3_exp[i]});
        end
        cond_valid = 1'b0;

        // Test 4: predicated block EQ, mask 010, Z=1
        write_flags(4'b0100);
        pred_start = 1'b1; pred_len = 3'd3; pred_cond = 4'h0; pred_mask = 4'b0010;
        tick();
        pred_start = 1'b0;
        chk("t4_pa_start", {3'b000, pa_d}, 4'h1);
        cond_valid = 1'b1; cond = 4'hF;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("t4_out_%0d", i), {3'b000, out_d}, {3'b000, t4_exp[i]});
            chk($sformatf("t4_pa_%0d", i), {3'b000, pa_d}, (i == 2) ? 4'h0 : 4'h1);
        end
        tick();
        chk("t4_after_nv", {3'b000, out_d}, 4'h0);
        cond_valid = 1'b0;

        // Test 5: stall in the middle of a 2-long block
        pred_start = 1'b1; pred_len = 3'd2; pred_cond = 4'h0; pred_mask = 4'b0001;
        tick();
        pred_start = 1'b0;
        cond_valid = 1'b1; cond = 4'hE;
        tick();
        chk("t5_first_ov", {3'b000, ov_d}, 4'h1);
        chk("t5_first", {3'b000, out_d}, 4'h0);
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("t5_hold_ov_%0d", i), {3'b000, ov_d}, 4'h1);
            chk($sformatf("t5_hold_out_%0d", i), {3'b000, out_d}, 4'h0);
            chk($sformatf("t5_hold_pa_%0d", i), {3'b000, pa_d}, 4'h1);
        end
        stall = 1'b0;
        tick();
        chk("t5_second", {3'b000, out_d}, 4'h1);
        chk("t5_pa_end", {3'b000, pa_d}, 4'h0);
        cond_valid = 1'b0;
        tick();
        chk("t5_ov_idle", {3'b000, ov_d}, 4'h0);

        // Test 6: flush mid-block, legacy encoding
        pred_start = 1'b1; pred_len = 3'd3; pred_cond = 4'b0011; pred_mask = 4'b0000;
        tick();
        pred_start = 1'b0;
        cond_valid = 1'b1; cond = 4'h0;
        tick();
        chk("t6_lg_lt", {3'b000, out_lg}, 4'h0);
        chk("t6_lg_pa", {3'b000, pa_lg}, 4'h1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("t6_flush_ov", {3'b000, ov_lg}, 4'h0);
        chk("t6_flush_pa", {3'b000, pa_lg}, 4'h0);
        chk("t6_flush_flags", fo_lg, 4'b0100);
        cond = 4'b0110;
        tick();
        chk("t6_lg_ge_ov", {3'b000, ov_lg}, 4'h1);
        chk("t6_lg_ge", {3'b000, out_lg}, 4'h1);
        chk("t6_full_vs", {3'b000, out_d}, 4'h0);
        cond_valid = 1'b0;

        // Oversized length is clamped to MAX_PRED
        pred_start = 1'b1; pred_len = 3'd7; pred_cond = 4'hE; pred_mask = 4'b0000;
        tick();
        pred_start = 1'b0;
        cond_valid = 1'b1; cond = 4'hF;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk($sformatf("clamp_out_%0d", i), {3'b000, out_d}, 4'h1);
            chk($sformatf("clamp_pa_%0d", i), {3'b000, pa_d}, (i == 3) ? 4'h0 : 4'h1);
        end
        cond_valid = 1'b0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
